ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_sync_edge.sv | 30 +++
 rtl/ps2_host_tx.sv | 167 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM encoding, default
// timing at a 50 MHz system clock, and common keyboard command bytes.
package ps2_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INHIBIT = 3'd1;
    localparam logic [2:0] ST_REQ     = 3'd2;
    localparam logic [2:0] ST_XFER    = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;
    localparam logic [2:0] ST_FINISH  = 3'd5;

    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_START_TIMEOUT  = 750000;
    localparam int DEF_PACKET_TIMEOUT = 100000;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam logic [3:0] EDGE_STOP = 4'd10;
    localparam logic [3:0] EDGE_ACK  = 4'd11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for one open-collector PS/2 line plus falling-edge
// detection on the synchronised value. Resets to the idle (high) bus level.
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic line_in,
    output logic line_sync,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= line_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign line_sync = sync;
    assign fall      = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, request-to-send, 11-bit frame, ack).
// Define PS2_TX_TIMEOUT_EN to compile in the start/packet watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
    parameter int PACKET_TIMEOUT = DEF_PACKET_TIMEOUT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] tx_byte,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int               INH_W    = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    logic [2:0]       state;
    logic [3:0]       edge_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic [9:0]       frame_r;
    logic             dat_bit;
    logic             done_r;
    logic             error_r;
    logic             clk_sync;
    logic             clk_fall;
    logic             dat_sync;
    logic             unused_dat_fall;
    logic             wd_expired;

    ps2_sync_edge u_clk_sync (
        .clock     (clock),
        .reset     (reset),
        .line_in   (ps2_clk_in),
        .line_sync (clk_sync),
        .fall      (clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clock     (clock),
        .reset     (reset),
        .line_in   (ps2_dat_in),
        .line_sync (dat_sync),
        .fall      (unused_dat_fall)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_MAX = (START_TIMEOUT > PACKET_TIMEOUT) ? START_TIMEOUT : PACKET_TIMEOUT;
    localparam int WD_W   = $clog2(WD_MAX + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            in_frame;

    assign in_frame = (state == ST_XFER) || (state == ST_ACK);

    // Counter restarts on the first device edge so the packet budget runs edge 1 to edge 11.
    always_ff @(posedge clock) begin
        if (reset)
            wd_cnt <= '0;
        else if (in_frame && !(clk_fall && edge_cnt == 4'd0))
            wd_cnt <= wd_cnt + WD_W'(1);
        else
            wd_cnt <= '0;
    end

    always_comb begin
        wd_expired = 1'b0;
        if (in_frame && !clk_fall) begin
            if (edge_cnt == 4'd0)
                wd_expired = (wd_cnt == WD_W'(START_TIMEOUT - 1));
            else
                wd_expired = (wd_cnt == WD_W'(PACKET_TIMEOUT - 1));
        end
    end
`else
    localparam int unused_timeouts = START_TIMEOUT + PACKET_TIMEOUT;
    assign wd_expired = 1'b0;
`endif

    // Frame shifts out LSB first: data[7:0], parity, then the stop bit (1 = released).
    always_ff @(posedge clock) begin
        if (state == ST_IDLE && send)
            frame_r <= {1'b1, odd_parity(tx_byte), tx_byte};
        else if (state == ST_XFER && clk_fall)
            frame_r <= {1'b0, frame_r[9:1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            edge_cnt <= '0;
            inh_cnt  <= '0;
            dat_bit  <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (send) begin
                        inh_cnt <= '0;
                        state   <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (inh_cnt == INH_LAST)
                        state <= ST_REQ;
                    else
                        inh_cnt <= inh_cnt + INH_W'(1);
                end
                ST_REQ: begin
                    edge_cnt <= '0;
                    dat_bit  <= 1'b1;
                    state    <= ST_XFER;
                end
                ST_XFER: begin
                    if (wd_expired) begin
                        error_r <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (clk_fall) begin
                        edge_cnt <= edge_cnt + 4'd1;
                        dat_bit  <= ~frame_r[0];
                        if (edge_cnt + 4'd1 == EDGE_STOP)
                            state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (wd_expired) begin
                        error_r <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (clk_fall) begin
                        edge_cnt <= EDGE_ACK;
                        if (!dat_sync) begin
                            state <= ST_FINISH;
                        end else begin
                            error_r <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_FINISH: begin
                    if (clk_sync && dat_sync) begin
                        done_r <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ps2_clk_oe = (state == ST_INHIBIT) || (state == ST_REQ);
    assign ps2_dat_oe = (state == ST_REQ) || ((state == ST_XFER) && dat_bit);
    assign busy       = (state != ST_IDLE);
    assign done       = done_r;
    assign error      = error_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// the observed data-line drive is compared against the frame the byte should produce.
module tb_ps2_host_tx;

    localparam int INH   = 5000;
    localparam int ST_TO = 2000;
    localparam int PK_TO = 1500;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       send    = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe, busy, done, error;

    // Open-collector bus: either side may pull a line low.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;
    int   n_err  = 0;
    logic send_q = 1'b0;
    logic reset_q = 1'b1;
    logic mb = 1'b0;
    logic expect_end = 1'b0;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (ST_TO),
        .PACKET_TIMEOUT (PK_TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .send       (send),
        .tx_byte    (tx_byte),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        send_q  <= send;
        reset_q <= reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Data-line drive after device edges 1..10: inverted data bits, inverted odd parity, stop.
    function automatic logic [9:0] model_bits(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b0, ~par, ~b};
    endfunction

    task automatic compare_loop();
        forever begin
            @(negedge clock);
            if (reset_q)
                mb = 1'b0;
            else if (send_q && !mb)
                mb = 1'b1;
            else if (done || error)
                mb = 1'b0;
            if (done)  n_done++;
            if (error) n_err++;
            check("busy", busy, mb);
            if (!mb)
                check("idle_lines", {ps2_clk_oe, ps2_dat_oe}, 0);
            if (done || error)
                check("pulse_legal", {done & error, ~expect_end}, 0);
        end
    endtask

    task automatic start_frame(input logic [7:0] b, input bit poke);
        int inh;
        int req;
        @(negedge clock);
        send = 1'b1;
        tx_byte = b;
        @(negedge clock);
        send = 1'b0;
        tx_byte = 8'($urandom);
        inh = 0;
        while (ps2_clk_oe && !ps2_dat_oe && inh < INH + 100) begin
            send = poke && (inh == 100);
            tx_byte = 8'($urandom);
            inh++;
            @(negedge clock);
        end
        send = 1'b0;
        check("inhibit_len", inh, INH);
        req = 0;
        while (ps2_clk_oe && ps2_dat_oe && req < 10) begin
            req++;
            @(negedge clock);
        end
        check("req_len", req, 1);
        check("start_hold", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
    endtask

    task automatic run_frame(input logic [7:0] b, input logic [9:0] exp, input bit ack_ok,
                             input int h, input int abort_at, input bit poke);
        int d0;
        int e0;
        int w;
        d0 = n_done;
        e0 = n_err;
        start_frame(b, poke);
        repeat (h) @(negedge clock);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) expect_end = 1'b1;
            dev_clk = 1'b0;
            repeat (h) @(negedge clock);
            if (k <= 10)
                check($sformatf("bit_after_edge%0d_byte%02h", k, b), ps2_dat_oe, exp[k-1]);
            if (k == abort_at) begin
                reset = 1'b1;
                dev_clk = 1'b1;
                @(negedge clock);
                check("abort_lines_busy", {ps2_clk_oe, ps2_dat_oe, busy}, 0);
                reset = 1'b0;
                repeat (8) @(negedge clock);
                return;
            end
            dev_clk = 1'b1;
            if (k == 10) dev_dat = ack_ok ? 1'b0 : 1'b1;
            repeat (h) @(negedge clock);
        end
        dev_dat = 1'b1;
        w = 0;
        while (busy && w < 50) begin
            w++;
            @(negedge clock);
        end
        check("frame_end_in_time", busy, 0);
        repeat (4) @(negedge clock);
        expect_end = 1'b0;
        check($sformatf("done_count_byte%02h", b), n_done - d0, ack_ok);
        check($sformatf("error_count_byte%02h", b), n_err - e0, !ack_ok);
    endtask

    initial begin
        int w;
        logic [7:0] rb;
        fork
            compare_loop();
        join_none
        repeat (3) @(negedge clock);
        check("reset_outputs", {busy, done, error, ps2_clk_oe, ps2_dat_oe}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        run_frame(8'hED, 10'h012, 1'b1, 8, 0, 1'b1);
        run_frame(8'h01, 10'h1FE, 1'b1, 8, 0, 1'b0);
        run_frame(8'hFF, 10'h000, 1'b1, 10, 0, 1'b0);
        run_frame(8'hEE, model_bits(8'hEE), 1'b0, 8, 0, 1'b0);
        run_frame(8'hED, 10'h012, 1'b1, 8, 5, 1'b0);
        run_frame(8'hF4, model_bits(8'hF4), 1'b1, 8, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            run_frame(rb, model_bits(rb), ($urandom_range(3) != 0), $urandom_range(12, 6), 0, 1'b1);
        end

`ifdef PS2_TX_TIMEOUT_EN
        start_frame(8'hEE, 1'b0);
        expect_end = 1'b1;
        w = 0;
        while (!error && w < ST_TO + 50) begin
            @(negedge clock);
            w++;
        end
        check("start_timeout_cycles", (w >= ST_TO) && (w <= ST_TO + 1), 1);
        check("timeout_lines", {error, ps2_clk_oe, ps2_dat_oe}, 3'b100);
        repeat (4) @(negedge clock);
        expect_end = 1'b0;
`else
        start_frame(8'hEE, 1'b0);
        w = 0;
        repeat (ST_TO + 100) @(negedge clock);
        check("no_watchdog_busy", busy, 1);
        check("no_watchdog_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
